adsr_env_mc: RTL and testbench
==============================

Name: adsr_env_mc

Overview:
Multi-voice ADSR envelope generator. It replaces the single-stage envelope NCO with a full attack/decay/sustain/release state machine per voice. Voices are time-multiplexed: each sample_rate strobe starts a sweep that updates one voice per clock and emits its level. The output feeds the per-voice amplitude scaler in the voice mixer.

Parameters:
VOICES, 4, number of voices (>=1); state held in per-voice register arrays
TIME_W, 7, width of the attack/decay/release time codes
OUT_W, 7, envelope level width; full scale = 2^OUT_W-1
ACC_W, 16, phase accumulator width per voice; must be >= TIME_W
VW, $clog2(VOICES) (min 1), voice index width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sample_rate  in  1  one-clock strobe that starts a sweep
gate  in  VOICES  per-voice note gate, level sensitive
attack_time  in  TIME_W  attack rate code (0 = fastest)
decay_time  in  TIME_W  decay rate code
sustain_level  in  OUT_W  sustain level, shared by all voices
release_time  in  TIME_W  release rate code
env_level  out  OUT_W  level of the voice just updated
env_voice  out  VW  index of that voice
env_stage  out  3  stage of that voice: 0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
env_dv  out  1  one-clock valid for env_level/env_voice/env_stage
env_ov  out  1  one-clock pulse: the updated voice stepped its level this sample
env_overrun  out  1  one-clock pulse: sample_rate arrived while a sweep was busy

Behaviour:
- Reset:
  - all voices IDLE, level 0, acc 0
  - sweep idle
  - all outputs 0
  - a reset mid-sweep aborts the sweep; no env_dv follows.
- Sweep start: sample_rate while not busy starts a sweep at cycle T.
  - Voice v is processed at cycle T+1+v.
  - Its registered result appears at T+2+v with env_dv=1.
  - env_dv is contiguous for VOICES clocks, then 0.
  - Inputs are sampled in the cycle the voice is processed.
- Overrun: sample_rate while busy is ignored, pulses env_overrun, and does not disturb the sweep. Integration must keep VOICES+2 below the sample period.
- Rate arithmetic:
  - Rate code t gives increment inc = 2^TIME_W - t, range 1..2^TIME_W, computed in TIME_W+1 bits.
  - The active stage's code is used; SUSTAIN and IDLE do not advance acc.
  - {carry, acc_next} = acc + inc, taken ACC_W+1 wide; acc keeps the low ACC_W bits (wraps).
  - carry=1 is a step event (env_ov=1 for that voice's output).
- Per-voice state machine, evaluated once per sweep per voice:
  - IDLE: gate=1 -> ATTACK, acc cleared. Level unchanged (0).
  - ATTACK: gate=0 -> RELEASE, acc cleared. Otherwise, on step, level+1. When level reaches 2^OUT_W-1 -> DECAY, acc cleared; level never exceeds full scale.
  - DECAY: gate=0 -> RELEASE. Otherwise, if level <= sustain_level -> SUSTAIN. Otherwise, on step, level-1.
  - SUSTAIN: level = sustain_level every sweep, tracking live changes. gate=0 -> RELEASE, acc cleared.
  - RELEASE: gate=1 -> ATTACK, acc cleared, starting from the current level (no reset to 0, retrigger without click). Otherwise, on step, level-1. When level reaches 0 -> IDLE.
- Priority: gate change first, then the step within the current stage.
  - A step and a stage exit in the same update: the step applies and the exit is checked on the new level.
  - An exit condition already true on entry (sustain_level = full scale, release from level 0) transitions on the next sweep with no level change.
- env_stage and env_level report the post-update state.
- A stage transition clears acc.

Test Plan:
1. VOICES=2, ACC_W=7, attack_time=0, gate[0]=1 held, sweeps continuous:
   - voice 0 level increments 1 per sweep with env_ov=1;
   - reaches 127 on sweep 127, stage DECAY from that output.
2. Continue with decay_time=0, sustain_level=100:
   - level 126..100 over 27 sweeps;
   - the next sweep reports SUSTAIN at 100;
   - changing sustain_level to 90 gives 90 on the next sweep.
3. ACC_W=7, attack_time=64 (inc 64):
   - level steps every 2nd sweep, env_ov alternating 0/1;
   - level 10 after 20 sweeps.
4. Release: from SUSTAIN at 90, drop gate[0], release_time=0:
   - RELEASE; level falls 1 per sweep to 0, then IDLE.
   - Raise gate at level 40 mid-release -> ATTACK from 40.
5. Voice independence: voice 0 gated and voice 1 not:
   - env_voice 0 then 1 on consecutive cycles;
   - voice 1 stays IDLE/0;
   - output latency is exactly T+2 and T+3.
6. Strobe sample_rate twice 1 clock apart:
   - single sweep and one env_overrun pulse.
   - Assert rst mid-sweep: outputs 0 next clock, no further env_dv.

Source files
------------

// File: rtl/adsr_env_mc.sv
`default_nettype none
// ============================================================================
// Module   : adsr_env_mc
// Brief    : Time-multiplexed multi-voice ADSR envelope generator; one voice
//            is updated per clock during a sweep started by sample_rate.
// Revision : 1.0 - initial release
// ============================================================================
module adsr_env_mc #(
    parameter int VOICES = 4,
    parameter int TIME_W = 7,
    parameter int OUT_W  = 7,
    parameter int ACC_W  = 16,
    parameter int VW     = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_rate,
    input  logic [VOICES-1:0] gate,
    input  logic [TIME_W-1:0] attack_time,
    input  logic [TIME_W-1:0] decay_time,
    input  logic [OUT_W-1:0]  sustain_level,
    input  logic [TIME_W-1:0] release_time,
    output logic [OUT_W-1:0]  env_level,
    output logic [VW-1:0]     env_voice,
    output logic [2:0]        env_stage,
    output logic              env_dv,
    output logic              env_ov,
    output logic              env_overrun
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } stage_t;

    localparam logic [OUT_W-1:0] c_full_scale = '1;
    localparam logic [VW-1:0]    c_last_voice = VW'(VOICES - 1);

    // Per-voice envelope state
    stage_t             r_stage [VOICES];
    logic [OUT_W-1:0]   r_level [VOICES];
    logic [ACC_W-1:0]   r_acc   [VOICES];

    // Sweep control
    logic               r_busy;
    logic [VW-1:0]      r_idx;

    // Registered outputs
    logic [OUT_W-1:0]   r_env_level;
    logic [VW-1:0]      r_env_voice;
    logic [2:0]         r_env_stage;
    logic               r_env_dv;
    logic               r_env_ov;
    logic               r_env_overrun;

    // Current voice view and next-state results
    stage_t             w_cur_stage;
    logic [OUT_W-1:0]   w_cur_level;
    logic [ACC_W-1:0]   w_cur_acc;
    logic               w_gate;
    logic [TIME_W-1:0]  w_code;
    logic [TIME_W:0]    w_inc;
    logic [ACC_W:0]     w_inc_ext;
    logic [ACC_W:0]     w_sum;
    logic               w_carry;
    stage_t             w_nstage;
    logic [OUT_W-1:0]   w_nlevel;
    logic [ACC_W-1:0]   w_nacc;
    logic               w_step;

    assign w_cur_stage = r_stage[r_idx];
    assign w_cur_level = r_level[r_idx];
    assign w_cur_acc   = r_acc[r_idx];
    assign w_gate      = gate[r_idx];

    // Rate code of the active stage; inc = 2^TIME_W - code, never zero
    always_comb begin
        w_code = '0;
        case (w_cur_stage)
            ST_ATTACK:  w_code = attack_time;
            ST_DECAY:   w_code = decay_time;
            ST_RELEASE: w_code = release_time;
            default:    w_code = '0;
        endcase
        w_inc              = {1'b1, {TIME_W{1'b0}}} - {1'b0, w_code};
        w_inc_ext          = '0;
        w_inc_ext[TIME_W:0] = w_inc;
        w_sum              = {1'b0, w_cur_acc} + w_inc_ext;
        w_carry            = w_sum[ACC_W];
    end

    // Next-state evaluation for the voice currently in the sweep slot
    always_comb begin
        w_nstage = w_cur_stage;
        w_nlevel = w_cur_level;
        w_nacc   = w_cur_acc;
        w_step   = 1'b0;
        case (w_cur_stage)
            ST_IDLE: begin
                if (w_gate) begin
                    w_nstage = ST_ATTACK;
                    w_nacc   = '0;
                end
            end
            ST_ATTACK: begin
                if (!w_gate) begin
                    w_nstage = ST_RELEASE;
                    w_nacc   = '0;
                end else begin
                    w_nacc = w_sum[ACC_W-1:0];
                    w_step = w_carry;
                    if (w_carry && (w_cur_level != c_full_scale))
                        w_nlevel = w_cur_level + 1'b1;
                    if (w_nlevel == c_full_scale) begin
                        w_nstage = ST_DECAY;
                        w_nacc   = '0;
                    end
                end
            end
            ST_DECAY: begin
                if (!w_gate) begin
                    w_nstage = ST_RELEASE;
                    w_nacc   = '0;
                end else if (w_cur_level <= sustain_level) begin
                    w_nstage = ST_SUSTAIN;
                    w_nacc   = '0;
                end else begin
                    // level > sustain_level here, so the decrement cannot wrap
                    w_nacc = w_sum[ACC_W-1:0];
                    w_step = w_carry;
                    if (w_carry)
                        w_nlevel = w_cur_level - 1'b1;
                end
            end
            ST_SUSTAIN: begin
                if (!w_gate) begin
                    w_nstage = ST_RELEASE;
                    w_nacc   = '0;
                end else begin
                    w_nlevel = sustain_level;
                end
            end
            ST_RELEASE: begin
                if (w_gate) begin
                    // Retrigger from the current level to avoid a click
                    w_nstage = ST_ATTACK;
                    w_nacc   = '0;
                end else begin
                    w_nacc = w_sum[ACC_W-1:0];
                    w_step = w_carry;
                    if (w_carry && (w_cur_level != '0))
                        w_nlevel = w_cur_level - 1'b1;
                    if (w_nlevel == '0) begin
                        w_nstage = ST_IDLE;
                        w_nacc   = '0;
                    end
                end
            end
            default: begin
                w_nstage = ST_IDLE;
                w_nlevel = '0;
                w_nacc   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VOICES; v++) begin
                r_stage[v] <= ST_IDLE;
                r_level[v] <= '0;
                r_acc[v]   <= '0;
            end
            r_busy        <= 1'b0;
            r_idx         <= '0;
            r_env_level   <= '0;
            r_env_voice   <= '0;
            r_env_stage   <= '0;
            r_env_dv      <= 1'b0;
            r_env_ov      <= 1'b0;
            r_env_overrun <= 1'b0;
        end else begin
            r_env_dv      <= 1'b0;
            r_env_ov      <= 1'b0;
            r_env_overrun <= sample_rate & r_busy;
            if (r_busy) begin
                r_stage[r_idx] <= w_nstage;
                r_level[r_idx] <= w_nlevel;
                r_acc[r_idx]   <= w_nacc;
                r_env_level    <= w_nlevel;
                r_env_voice    <= r_idx;
                r_env_stage    <= w_nstage;
                r_env_dv       <= 1'b1;
                r_env_ov       <= w_step;
                if (r_idx == c_last_voice) begin
                    r_busy <= 1'b0;
                    r_idx  <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end else if (sample_rate) begin
                r_busy <= 1'b1;
                r_idx  <= '0;
            end
        end
    end

    assign env_level   = r_env_level;
    assign env_voice   = r_env_voice;
    assign env_stage   = r_env_stage;
    assign env_dv      = r_env_dv;
    assign env_ov      = r_env_ov;
    assign env_overrun = r_env_overrun;

endmodule
`default_nettype wire

// File: tb/tb_adsr_env_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_adsr_env_mc
// Brief    : Directed table-driven bench for adsr_env_mc (2 voices, 7-bit acc).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adsr_env_mc;

    localparam int VOICES = 2;
    localparam int TIME_W = 7;
    localparam int OUT_W  = 7;
    localparam int ACC_W  = 7;
    localparam int VW     = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_rate;
    logic [VOICES-1:0] gate;
    logic [TIME_W-1:0] attack_time;
    logic [TIME_W-1:0] decay_time;
    logic [OUT_W-1:0]  sustain_level;
    logic [TIME_W-1:0] release_time;
    logic [OUT_W-1:0]  env_level;
    logic [VW-1:0]     env_voice;
    logic [2:0]        env_stage;
    logic              env_dv;
    logic              env_ov;
    logic              env_overrun;

    adsr_env_mc #(
        .VOICES(VOICES), .TIME_W(TIME_W), .OUT_W(OUT_W), .ACC_W(ACC_W), .VW(VW)
    ) dut (
        .clk(clk), .rst(rst), .sample_rate(sample_rate), .gate(gate),
        .attack_time(attack_time), .decay_time(decay_time),
        .sustain_level(sustain_level), .release_time(release_time),
        .env_level(env_level), .env_voice(env_voice), .env_stage(env_stage),
        .env_dv(env_dv), .env_ov(env_ov), .env_overrun(env_overrun)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int lv [VOICES];
    int st [VOICES];
    int ov [VOICES];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One strobe; voice v must appear exactly v+2 edges after the strobe edge
    task automatic sweep();
        @(negedge clk) sample_rate = 1'b1;
        @(negedge clk) sample_rate = 1'b0;
        chk("dv_before_first_voice", env_dv, 0);
        for (int v = 0; v < VOICES; v++) begin
            @(negedge clk);
            chk("dv_in_sweep", env_dv, 1);
            chk("voice_order", env_voice, v);
            lv[v] = env_level;
            st[v] = env_stage;
            ov[v] = env_ov;
        end
        @(negedge clk);
        chk("dv_after_sweep", env_dv, 0);
    endtask

    typedef struct {
        int g, at, dt, sl, rt, n;
        int lvl, stg, ovf;
    } vec_t;

    vec_t tbl [28];

    initial begin
        // g  at dt  sl  rt   n  lvl stg ov   (voice 0; last sweep of the row)
        tbl[0]  = '{1,  0, 0, 100,   0,   1,   0, 1, 0};
        tbl[1]  = '{1,  0, 0, 100,   0,   1,   1, 1, 1};
        tbl[2]  = '{1,  0, 0, 100,   0, 125, 126, 1, 1};
        tbl[3]  = '{1,  0, 0, 100,   0,   1, 127, 2, 1};
        tbl[4]  = '{1,  0, 0, 100,   0,   1, 126, 2, 1};
        tbl[5]  = '{1,  0, 0, 100,   0,  25, 101, 2, 1};
        tbl[6]  = '{1,  0, 0, 100,   0,   1, 100, 2, 1};
        tbl[7]  = '{1,  0, 0, 100,   0,   1, 100, 3, 0};
        tbl[8]  = '{1,  0, 0,  90,   0,   1,  90, 3, 0};
        tbl[9]  = '{0,  0, 0,  90,   0,   1,  90, 4, 0};
        tbl[10] = '{0,  0, 0,  90,   0,   1,  89, 4, 1};
        tbl[11] = '{0,  0, 0,  90,   0,  48,  41, 4, 1};
        tbl[12] = '{0,  0, 0,  90,   0,   1,  40, 4, 1};
        tbl[13] = '{1, 64, 0,  90,   0,   1,  40, 1, 0};
        tbl[14] = '{1, 64, 0,  90,   0,   1,  40, 1, 0};
        tbl[15] = '{1, 64, 0,  90,   0,   1,  41, 1, 1};
        tbl[16] = '{1, 64, 0,  90,   0,  18,  50, 1, 1};
        tbl[17] = '{1, 64, 0,  90,   0,   1,  50, 1, 0};
        tbl[18] = '{0, 64, 0,  90,   0,   1,  50, 4, 0};
        tbl[19] = '{0, 64, 0,  90,   0,  49,   1, 4, 1};
        tbl[20] = '{0, 64, 0,  90,   0,   1,   0, 0, 1};
        tbl[21] = '{0, 64, 0,  90,   0,   1,   0, 0, 0};
        tbl[22] = '{1,  0, 0,  90,   0,   1,   0, 1, 0};
        tbl[23] = '{1,  0, 0,  90,   0, 127, 127, 2, 1};
        tbl[24] = '{1,  0, 0, 127,   0,   1, 127, 3, 0};
        tbl[25] = '{1,  0, 0,   0,   0,   1,   0, 3, 0};
        tbl[26] = '{0,  0, 0,   0, 127,   1,   0, 4, 0};
        tbl[27] = '{0,  0, 0,   0, 127,   1,   0, 0, 0};

        rst = 1'b1; sample_rate = 1'b0; gate = '0;
        attack_time = '0; decay_time = '0; sustain_level = '0; release_time = '0;
        repeat (3) @(negedge clk);
        chk("rst_level",   env_level,   0);
        chk("rst_stage",   env_stage,   0);
        chk("rst_dv",      env_dv,      0);
        chk("rst_ov",      env_ov,      0);
        chk("rst_overrun", env_overrun, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            gate          = {1'b0, 1'(tbl[i].g)};
            attack_time   = TIME_W'(tbl[i].at);
            decay_time    = TIME_W'(tbl[i].dt);
            sustain_level = OUT_W'(tbl[i].sl);
            release_time  = TIME_W'(tbl[i].rt);
            for (int k = 0; k < tbl[i].n; k++) sweep();
            chk($sformatf("row%0d_level", i), lv[0], tbl[i].lvl);
            chk($sformatf("row%0d_stage", i), st[0], tbl[i].stg);
            chk($sformatf("row%0d_ov", i),    ov[0], tbl[i].ovf);
            chk($sformatf("row%0d_v1_level", i), lv[1], 0);
            chk($sformatf("row%0d_v1_stage", i), st[1], 0);
        end

        // Second strobe while busy: one overrun pulse, sweep undisturbed
        gate = '0;
        @(negedge clk) sample_rate = 1'b1;
        @(negedge clk) sample_rate = 1'b1;
        chk("ovr_not_yet", env_overrun, 0);
        @(negedge clk) sample_rate = 1'b0;
        chk("ovr_pulse", env_overrun, 1);
        chk("ovr_dv0", env_dv, 1);
        chk("ovr_voice0", env_voice, 0);
        @(negedge clk);
        chk("ovr_cleared", env_overrun, 0);
        chk("ovr_dv1", env_dv, 1);
        chk("ovr_voice1", env_voice, 1);
        repeat (2) begin
            @(negedge clk);
            chk("ovr_no_second_sweep", env_dv, 0);
            chk("ovr_single_pulse", env_overrun, 0);
        end

        // Reset in the middle of a sweep
        gate = 2'b01;
        @(negedge clk) sample_rate = 1'b1;
        @(negedge clk) sample_rate = 1'b0;
        @(negedge clk);
        chk("mid_dv", env_dv, 1);
        chk("mid_stage", env_stage, 1);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("mid_rst_dv",      env_dv,      0);
        chk("mid_rst_level",   env_level,   0);
        chk("mid_rst_stage",   env_stage,   0);
        chk("mid_rst_voice",   env_voice,   0);
        chk("mid_rst_ov",      env_ov,      0);
        chk("mid_rst_overrun", env_overrun, 0);
        repeat (4) begin
            @(negedge clk);
            chk("mid_rst_no_dv", env_dv, 0);
        end
        gate = '0;
        sweep();
        chk("post_rst_v0_stage", st[0], 0);
        chk("post_rst_v0_level", lv[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
